// File: rtl/led_pkg.sv
// Shared constants, slot-state type and hex-to-segment mapping for the
// 8-digit multiplexed 7-segment display controller.
package led_pkg;

  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam logic [7:0] DIG_OFF    = 8'hFF;
  localparam int         WORD_W     = 32;
  localparam int         NUM_DIGITS = 8;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } slot_state_e;

  // Active-low {a,b,c,d,e,f,g,dp}; dp is always held off.
  function automatic logic [7:0] hex_to_seg7(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0:    seg = 8'h03;
      4'h1:    seg = 8'h9F;
      4'h2:    seg = 8'h25;
      4'h3:    seg = 8'h0D;
      4'h4:    seg = 8'h99;
      4'h5:    seg = 8'h49;
      4'h6:    seg = 8'h41;
      4'h7:    seg = 8'h1B;
      4'h8:    seg = 8'h01;
      4'h9:    seg = 8'h09;
      4'hA:    seg = 8'h11;
      4'hB:    seg = 8'hC1;
      4'hC:    seg = 8'h63;
      4'hD:    seg = 8'h85;
      4'hE:    seg = 8'h61;
      4'hF:    seg = 8'h71;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-segment decoder; active-low outputs.
module seg7_hex_decode
  import led_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg_n
);

  // Pure table lookup through the shared mapping function.
  always_comb begin
    seg_n = hex_to_seg7(nibble);
  end

endmodule

// File: rtl/led_display_ctrl.sv
// Display scan controller: per-frame snapshot of the granted source word,
// digit multiplexing with blanking, and hold-limited round-robin arbitration.
module led_display_ctrl
  import led_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int HOLD_FRAMES  = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        src_req,
  input  logic [WORD_W*NUM_SRC-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_grant,
  output logic                      frame_done,
  output logic [7:0]                display_data,
  output logic [7:0]                display_en
);

  localparam int CNT_W  = $clog2(PRESCALE);
  localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0]  CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_FRAMES);
  localparam logic [2:0]        DIG_LAST  = 3'd7;
  localparam slot_state_e       STATE_RST = (BLANK_CYCLES > 0) ? BLANK : DRIVE;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         dig_q, dig_d;
  slot_state_e        state_q, state_d;
  logic [WORD_W-1:0]  snap_q, snap_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic               frame_done_q, frame_done_d;
  logic [7:0]         data_q, data_d;
  logic [7:0]         en_q, en_d;

  logic               frame_end_s;
  logic               snap_load_s;
  logic [WORD_W-1:0]  owner_word_s;
  logic [WORD_W-1:0]  snap_eff_s;
  logic [3:0]         nibble_s;
  logic [7:0]         seg_s;
  logic               rearb_s;
  logic               found_s;
  logic [IDX_W-1:0]   winner_s;

  assign frame_end_s  = (cnt_q == CNT_LAST) && (dig_q == DIG_LAST);
  assign snap_load_s  = (cnt_q == '0) && (dig_q == 3'd0);
  assign owner_word_s = src_data[WORD_W*int'(owner_q) +: WORD_W];
  // On the snapshot cycle the live word is used so a zero-blank slot never shows stale data.
  assign snap_eff_s   = snap_load_s ? owner_word_s : snap_q;
  assign nibble_s     = snap_eff_s[{dig_q, 2'b00} +: 4];
  assign rearb_s      = ((int'(hold_q) + 32'sd1) >= HOLD_FRAMES) || !src_req[owner_q];

  seg7_hex_decode u_dec (
    .nibble (nibble_s),
    .seg_n  (seg_s)
  );

  // Slot and digit counters; the digit wraps naturally at 3 bits.
  always_comb begin
    cnt_d = cnt_q;
    dig_d = dig_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      dig_d = dig_q + 3'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    frame_done_d = (cnt_d == CNT_LAST) && (dig_d == DIG_LAST);
    snap_d       = snap_eff_s;
  end

  // Slot FSM next state and the pin values for the current slot position.
  always_comb begin
    state_d = state_q;
    en_d    = DIG_OFF;
    data_d  = SEG_BLANK;
    case (state_q)
      BLANK: begin
        if (cnt_d >= CNT_BLANK) begin
          state_d = DRIVE;
        end else begin
          state_d = BLANK;
        end
      end
      DRIVE: begin
        en_d   = ~(8'b0000_0001 << dig_q);
        data_d = seg_s;
        if ((BLANK_CYCLES > 0) && (cnt_d == '0)) begin
          state_d = BLANK;
        end else begin
          state_d = DRIVE;
        end
      end
      default: begin
        state_d = STATE_RST;
      end
    endcase
  end

  // Rotate-and-priority-encode: scan sources after the owner, owner last.
  always_comb begin
    found_s  = 1'b0;
    winner_s = owner_q;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (!found_s && src_req[IDX_W'((int'(owner_q) + k) % NUM_SRC)]) begin
        found_s  = 1'b1;
        winner_s = IDX_W'((int'(owner_q) + k) % NUM_SRC);
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Grant and hold bookkeeping, evaluated only on the last cycle of a frame.
  always_comb begin
    owner_d = owner_q;
    grant_d = grant_q;
    hold_d  = hold_q;
    if (frame_end_s) begin
      if (rearb_s && found_s && (winner_s != owner_q)) begin
        owner_d = winner_s;
        grant_d = NUM_SRC'(1) << winner_s;
        hold_d  = '0;
      end else if (hold_q != HOLD_MAX) begin
        hold_d = hold_q + HOLD_W'(1);
      end else begin
        hold_d = hold_q;
      end
    end else begin
      hold_d = hold_q;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      dig_q        <= 3'd0;
      state_q      <= STATE_RST;
      snap_q       <= '0;
      hold_q       <= '0;
      owner_q      <= '0;
      grant_q      <= NUM_SRC'(1);
      frame_done_q <= 1'b0;
      data_q       <= SEG_BLANK;
      en_q         <= DIG_OFF;
    end else begin
      cnt_q        <= cnt_d;
      dig_q        <= dig_d;
      state_q      <= state_d;
      snap_q       <= snap_d;
      hold_q       <= hold_d;
      owner_q      <= owner_d;
      grant_q      <= grant_d;
      frame_done_q <= frame_done_d;
      data_q       <= data_d;
      en_q         <= en_d;
    end
  end

  assign src_grant    = grant_q;
  assign frame_done   = frame_done_q;
  assign display_data = data_q;
  assign display_en   = en_q;

endmodule

// File: tb/tb_led_display_ctrl.sv
// Self-checking bench for led_display_ctrl against a cycle-indexed reference model.
module tb_led_display_ctrl;

  localparam int N     = 4;
  localparam int P     = 4;
  localparam int B     = 1;
  localparam int H     = 2;
  localparam int FRAME = 8 * P;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    src_req;
  logic [32*N-1:0] src_data;
  logic [N-1:0]    src_grant;
  logic            frame_done;
  logic [7:0]      display_data;
  logic [7:0]      display_en;

  logic [31:0] word [N];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, indexed by cycle number since reset release.
  int          m_t;
  int          m_owner;
  int          m_hold;
  logic [31:0] m_snap;
  logic [7:0]  exp_en;
  logic [7:0]  exp_data;
  logic        exp_fd;
  logic [N-1:0] exp_grant;

  logic [7:0] seg_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1B,
                               8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
  logic [N-1:0] rr_tab [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                               4'b0100, 4'b1000, 4'b1000, 4'b0001};

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) src_data[32*i +: 32] = word[i];
  end

  led_display_ctrl #(
    .NUM_SRC(N), .PRESCALE(P), .BLANK_CYCLES(B), .HOLD_FRAMES(H)
  ) dut (
    .clk(clk), .rst_n(rst_n), .src_req(src_req), .src_data(src_data),
    .src_grant(src_grant), .frame_done(frame_done),
    .display_data(display_data), .display_en(display_en)
  );

  task automatic model_reset();
    m_t = 0; m_owner = 0; m_hold = 0; m_snap = 32'h0;
  endtask

  // Predict what the pins show after the current cycle, then clock it.
  task automatic run_cycle();
    int pos, dg, win, c;
    pos = m_t % P;
    dg  = (m_t / P) % 8;
    if (m_t % FRAME == 0) m_snap = word[m_owner];
    if (pos < B) begin
      exp_en = 8'hFF; exp_data = 8'hFF;
    end else begin
      exp_en = ~(8'h01 << dg); exp_data = seg_tab[m_snap[4*dg +: 4]];
    end
    if (m_t % FRAME == FRAME - 1) begin
      win = -1;
      if (m_hold + 1 >= H || !src_req[m_owner]) begin
        for (int k = 1; k <= N; k++) begin
          c = (m_owner + k) % N;
          if (win < 0 && src_req[c]) win = c;
        end
      end
      if (win >= 0 && win != m_owner) begin
        m_owner = win; m_hold = 0;
      end else begin
        m_hold = (m_hold + 1 > H) ? H : m_hold + 1;
      end
    end
    exp_fd    = ((m_t + 1) % FRAME == FRAME - 1);
    exp_grant = 4'b0001 << m_owner;
    @(posedge clk); #1;
    m_t++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    src_req = 4'b1111;
    for (int i = 0; i < N; i++) word[i] = $urandom;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    model_reset();
    repeat (70) run_cycle();
    rst_n = 1'b0;
    for (int i = 0; i <= 3; i++) begin
      if (i < 3) begin @(posedge clk); #1; end
      else begin rst_n = 1'b1; model_reset(); end
      n_tests++;
      if (display_data !== 8'hFF) begin n_fail++; $display("FAIL reset_data step=%0d got %h exp ff", i, display_data); end
      n_tests++;
      if (display_en !== 8'hFF) begin n_fail++; $display("FAIL reset_en step=%0d got %h exp ff", i, display_en); end
      n_tests++;
      if (src_grant !== 4'b0001) begin n_fail++; $display("FAIL reset_grant step=%0d got %b exp 0001", i, src_grant); end
      n_tests++;
      if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd step=%0d got %b exp 0", i, frame_done); end
    end
  endtask

  task automatic test_scan();
    int fd_count;
    word[0] = 32'h12345678;
    src_req = 4'b0001;
    do_reset();
    fd_count = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      run_cycle();
      if (frame_done === 1'b1) fd_count++;
      n_tests++;
      if (display_en !== exp_en || display_data !== exp_data) begin
        n_fail++; $display("FAIL scan_pins cyc=%0d got en=%h data=%h exp en=%h data=%h", i, display_en, display_data, exp_en, exp_data);
      end
      n_tests++;
      if (frame_done !== exp_fd) begin n_fail++; $display("FAIL scan_fd cyc=%0d got %b exp %b", i, frame_done, exp_fd); end
      if (i == 2 || i == 5 || i == 29) begin
        n_tests++;
        if ((i == 2 && {display_en, display_data} !== 16'hFE01) ||
            (i == 5 && {display_en, display_data} !== 16'hFD1B) ||
            (i == 29 && {display_en, display_data} !== 16'h7F9F)) begin
          n_fail++; $display("FAIL scan_fixed cyc=%0d got en=%h data=%h", i, display_en, display_data);
        end
      end
    end
    n_tests++;
    if (fd_count != 2) begin n_fail++; $display("FAIL scan_fd_count got %0d exp 2", fd_count); end
  endtask

  task automatic test_no_tear();
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (i == 12) word[0] = 32'hFFFFFFFF;
      run_cycle();
      n_tests++;
      if (display_en !== exp_en || display_data !== exp_data) begin
        n_fail++; $display("FAIL tear_pins cyc=%0d got en=%h data=%h exp en=%h data=%h", i, display_en, display_data, exp_en, exp_data);
      end
      if (i == 13) begin
        n_tests++;
        if (display_data !== 8'h49) begin n_fail++; $display("FAIL tear_old_digit3 got %h exp 49", display_data); end
      end
      if (i == 33) begin
        n_tests++;
        if (display_data !== 8'h71) begin n_fail++; $display("FAIL tear_new_digit0 got %h exp 71", display_data); end
      end
    end
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < N; i++) word[i] = $urandom;
    src_req = 4'b1111;
    do_reset();
    for (int f = 0; f < 9; f++) begin
      n_tests++;
      if (src_grant !== rr_tab[f]) begin n_fail++; $display("FAIL rr_seq frame=%0d got %b exp %b", f, src_grant, rr_tab[f]); end
      for (int i = 0; i < FRAME; i++) begin
        run_cycle();
        n_tests++;
        if (src_grant !== exp_grant || frame_done !== exp_fd) begin
          n_fail++; $display("FAIL rr_model frame=%0d cyc=%0d got g=%b fd=%b exp g=%b fd=%b", f, i, src_grant, frame_done, exp_grant, exp_fd);
        end
      end
    end
  endtask

  task automatic test_owner_drop();
    logic [N-1:0] want;
    src_req = 4'b0010;
    do_reset();
    repeat (FRAME) run_cycle();
    n_tests++;
    if (src_grant !== 4'b0010) begin n_fail++; $display("FAIL drop_setup got %b exp 0010", src_grant); end
    src_req = 4'b0111;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (i == 12) src_req = 4'b0101;
      run_cycle();
      want = (i < FRAME - 1) ? 4'b0010 : 4'b0100;
      n_tests++;
      if (src_grant !== want || src_grant !== exp_grant) begin
        n_fail++; $display("FAIL drop_grant cyc=%0d got %b exp %b", i, src_grant, want);
      end
    end
  endtask

  task automatic test_idle();
    src_req = 4'b0000;
    for (int i = 0; i < 5 * FRAME; i++) begin
      if (i % 7 == 3) word[$urandom_range(N-1, 0)] = $urandom;
      run_cycle();
      n_tests++;
      if (src_grant !== 4'b0100) begin n_fail++; $display("FAIL idle_grant cyc=%0d got %b exp 0100", i, src_grant); end
      n_tests++;
      if (display_en !== exp_en || display_data !== exp_data) begin
        n_fail++; $display("FAIL idle_pins cyc=%0d got en=%h data=%h exp en=%h data=%h", i, display_en, display_data, exp_en, exp_data);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8 * FRAME; i++) begin
      if (i % 5 == 0) src_req = 4'($urandom);
      if (i % 3 == 0) word[$urandom_range(N-1, 0)] = $urandom;
      run_cycle();
      n_tests++;
      if (display_en !== exp_en || display_data !== exp_data || src_grant !== exp_grant || frame_done !== exp_fd) begin
        n_fail++; $display("FAIL rand cyc=%0d got en=%h d=%h g=%b fd=%b exp en=%h d=%h g=%b fd=%b", i,
                           display_en, display_data, src_grant, frame_done, exp_en, exp_data, exp_grant, exp_fd);
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    src_req = '0;
    for (int i = 0; i < N; i++) word[i] = 32'h0;
    model_reset();
    test_reset();
    test_scan();
    test_no_tear();
    test_round_robin();
    test_owner_drop();
    test_idle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_display_ctrl.md
# led_display_ctrl

Scan controller and source arbiter for the board's 8-digit 7-segment display. Shares the display between up to NUM_SRC requesters, such as PC, ALU result and register-debug probes. It latches the granted source's 32-bit word once per frame, so digits never tear mid-frame. It also sequences digit multiplexing at a programmable refresh rate, with an anti-ghosting blank interval. It drives the segment and anode pins directly.

## Interface
- NUM_SRC, 4: number of requesters (≥1)
- PRESCALE, 1000: clk cycles per digit slot (≥2)
- BLANK_CYCLES, 16: cycles at slot start with all digits off (0 ≤ BLANK_CYCLES < PRESCALE)
- HOLD_FRAMES, 64: minimum frames a granted source keeps the display while others request (≥1)
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- src_req  in  NUM_SRC  request per source, level-sensitive
- src_data  in  32*NUM_SRC  source i word at bits [32i+31:32i]
- src_grant  out  NUM_SRC  one-hot current owner
- frame_done  out  1  one-cycle pulse at the last cycle of each frame
- display_data  out  8  active-low segments {a,b,c,d,e,f,g,dp}; dp always off (1)
- display_en  out  8  active-low digit enables; bit i = digit i

## Operation
- Slot counter cnt: 0..PRESCALE-1. Digit counter dig: 0..7, increments when cnt wraps; wraps 7→0.
- Frame = 8 slots = 8*PRESCALE cycles.
- FSM per slot:
  - BLANK while cnt < BLANK_CYCLES.
  - DRIVE for the rest of the slot.
  - If BLANK_CYCLES=0, DRIVE for the whole slot.
- Snapshot: on cycles where dig=0 and cnt=0, snap ← src_data word of the granted source. This includes the first cycle after reset release.
- Digit i shows snap[4i+3:4i].
- Hex decode is active-low: 0→0x03, 1→0x9F, 2→0x25, 3→0x0D, 4→0x99, 5→0x49, 6→0x41, 7→0x1B, 8→0x01, 9→0x09, A→0x11, B→0xC1, C→0x63, D→0x85, E→0x61, F→0x71.
- In BLANK: display_en=0xFF and display_data=0xFF.
- In DRIVE: display_en has only bit dig low; display_data is the decoded nibble.
- Arbitration runs only at frame end (dig=7, cnt=PRESCALE-1), the same cycle frame_done=1.
  - hold_cnt counts completed frames of the current owner and saturates at HOLD_FRAMES.
  - Re-arbitrate if hold_cnt+1 ≥ HOLD_FRAMES, or if the owner's src_req=0.
  - Round-robin: the first requesting source after the current owner, in ascending index with wrap, wins. The owner is considered last.
  - If no source requests, the grant is unchanged.
  - On a grant change, hold_cnt ← 0; otherwise hold_cnt increments, saturating.
- src_req changes mid-frame have no effect until the frame end.

## Timing
- All outputs are registered. display_data and display_en reflect the state (cnt, dig, snap) of the previous cycle: one cycle of latency.
- src_grant and frame_done are registered from the arbitration decision.
  - The new grant is visible the cycle after frame_done.
  - The new grant is sampled for the snapshot on that same cycle (dig=0, cnt=0).
  - The new owner's data appears on the pins BLANK_CYCLES+1 cycles later.
- Reset values: display_data=0xFF, display_en=0xFF, src_grant=1 (source 0), frame_done=0, cnt=0, dig=0, snap=0, hold_cnt=0, FSM=BLANK.
- Reset mid-frame: all state returns to reset values on the next clk edge. The next frame starts immediately after release.
- Simultaneous owner-drop and hold expiry: a single re-arbitration, same rule.
- NUM_SRC=1: grant stays at 1; hold logic is inert.

## Structure
- Shared package led_pkg:
  - seg7 code constants (SEG_BLANK=8'hFF, DIG_OFF=8'hFF)
  - the hex-to-segment function
  - the slot state enum {BLANK, DRIVE}
- One sub-module, seg7_hex_decode: 4-bit nibble in, 8-bit active-low segments out, combinational.
- The round-robin arbiter stays inline: a small rotate-and-priority-encode loop.

## Test plan
- Reset: hold rst_n=0 for 3 cycles during activity → display_data=0xFF, display_en=0xFF, src_grant=0001, frame_done=0, throughout and on the first cycle after release.
- Scan, PRESCALE=4, BLANK_CYCLES=1, source 0 requesting with 0x12345678:
  - Per slot, one blank cycle, then 3 cycles with en=0xFE and data=0x01 (digit 0 = '8').
  - Next slot: en=0xFD, data=0x1B ('7').
  - Slot 7: en=0x7F, data=0x9F ('1').
  - frame_done pulses every 32 cycles.
- No tearing: change source 0 data to 0xFFFFFFFF at dig=3 → digits 3–7 still show the old nibbles. The new word appears only from digit 0 of the next frame (0x71).
- Round-robin with hold, HOLD_FRAMES=2, all 4 sources requesting → grant sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001, one grant per frame.
- Owner drop: source 1 owns, hold not expired, src_req=0101, drop source 1 mid-frame → at frame end grant→0100 (source 2), hold_cnt=0. No change before frame_done.
- Idle: src_req=0 for 5 frames → grant unchanged. The display keeps refreshing snapshots from the owner's current src_data.
